landrover_gear_fsm: RTL and testbench
=====================================

LANDROVER_GEAR_FSM -- requirements
Module: landrover_gear_fsm

Interface
REQ-001 SHALL have parameter NUM_GEARS, default 5, number of forward gears; legal range 2..(2^GEAR_W)-2.
REQ-002 SHALL have parameter GEAR_W, default 3, width of gear output.
REQ-003 SHALL have parameter DWELL_CYCLES, default 4, shift dwell length in clocks; minimum 1.
REQ-004 SHALL have parameter CNT_W, default 8, width of shift counter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port shift_up  input  1  level request for next higher gear.
REQ-008 SHALL have port shift_down  input  1  level request for next lower gear.
REQ-009 SHALL have port brake  input  1  brake pedal; qualifies engagement from neutral.
REQ-010 SHALL have port state  output  3  current FSM state encoding.
REQ-011 SHALL have port gear  output  GEAR_W  engaged gear.
REQ-012 SHALL have port busy  output  1  high while a shift dwell is in progress.
REQ-013 SHALL have port conflict  output  1  one-cycle pulse on simultaneous request edges.
REQ-014 SHALL have port shift_count  output  CNT_W  number of completed shifts.

Function
REQ-015 SHALL encode states as NEUTRAL=000, DRIVE=001, SHIFT=010, REVERSE=011; other codes unreachable, and any other code SHALL return to NEUTRAL on the next edge.
REQ-016 SHALL act only on rising edges of shift_up and shift_down (input high now, low previous cycle); held levels SHALL cause no further action.
REQ-017 SHALL treat same-cycle rising edges on both shift_up and shift_down as no action, and pulse conflict high for exactly one cycle.
REQ-018 In NEUTRAL with gear=0: a shift_up edge with brake=1 SHALL enter SHIFT with target 1; a shift_up edge with brake=0 SHALL be ignored.
REQ-019 In DRIVE: a shift_up edge with gear<NUM_GEARS SHALL enter SHIFT with target gear+1; at gear=NUM_GEARS it SHALL be ignored (saturate, no wrap).
REQ-020 In DRIVE: a shift_down edge with gear>1 SHALL enter SHIFT with target gear-1; at gear=1 it SHALL go directly to NEUTRAL with gear=0 on the next edge, no dwell, counter unchanged.
REQ-021 On SHIFT entry, the dwell counter SHALL load DWELL_CYCLES-1, decrement each cycle, and the block SHALL hold busy=1 and gear at its old value throughout.
REQ-022 On the edge where the dwell counter is 0 in SHIFT, gear SHALL take the target value, state SHALL become DRIVE, busy SHALL fall, and shift_count SHALL increment.
REQ-023 A request edge at edge k SHALL give state=SHIFT after edge k and the new gear after edge k+DWELL_CYCLES.
REQ-024 Request edges and brake during SHIFT SHALL be ignored; edge-detect history SHALL still update.
REQ-025 shift_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 gear and state SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-027 reset=0 SHALL immediately force state=NEUTRAL, gear=0, busy=0, conflict=0, shift_count=0, dwell counter=0, and edge history=0, independent of clk.
REQ-028 Reset asserted mid-SHIFT SHALL abandon the shift with no gear change and no count increment.
REQ-029 The first rising clk edge after reset releases SHALL treat any already-high request as a rising edge.

Configuration
REQ-030 With macro LANDROVER_REVERSE_EN defined, a shift_down edge in NEUTRAL with brake=1 SHALL enter REVERSE with gear={GEAR_W{1}}, and a shift_up edge in REVERSE with brake=1 SHALL return to NEUTRAL with gear=0.
REQ-031 Without LANDROVER_REVERSE_EN, REVERSE SHALL be unreachable, and a shift_down edge in NEUTRAL SHALL be ignored.

Verification
REQ-032 Reset low, then release; pulse shift_up with brake=0: expect state=000 and gear=0 throughout.
REQ-033 brake=1, pulse shift_up at edge k: expect state=010 and busy=1 for 4 cycles, then gear=1, state=001, shift_count=1 after edge k+4.
REQ-034 Drive to gear 5, then pulse shift_up: expect gear stays 5 with no SHIFT entry; hold shift_up high 10 cycles: expect one shift at most.
REQ-035 Raise shift_up and shift_down in the same cycle in DRIVE gear 3: expect conflict high for one cycle and gear stays 3; at gear 1, a shift_down edge gives state=000 and gear=0 after one edge.
REQ-036 Assert reset 2 cycles into a shift from gear 2 to 3: expect gear=0, state=000, busy=0, and shift_count=0 immediately.
REQ-037 With LANDROVER_REVERSE_EN, brake=1 and a shift_down edge in NEUTRAL: expect state=011 and gear=111; without the macro, expect state=000 and gear=000.

Source files
------------

// File: rtl/landrover_gear_fsm.sv
// Gear selector FSM: edge-triggered up/down requests, timed shift dwell, saturating shift counter.
// Optional reverse gear is enabled by defining LANDROVER_REVERSE_EN.
module landrover_gear_fsm #(
  parameter int NUM_GEARS    = 5,
  parameter int GEAR_W       = 3,
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_up,
  input  logic              shift_down,
  input  logic              brake,
  output logic [2:0]        state,
  output logic [GEAR_W-1:0] gear,
  output logic              busy,
  output logic              conflict,
  output logic [CNT_W-1:0]  shift_count
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [GEAR_W-1:0]  TOP_GEAR   = GEAR_W'(NUM_GEARS);
  localparam logic [GEAR_W-1:0]  FIRST_GEAR = GEAR_W'(1);

  typedef enum logic [2:0] {
    NEUTRAL = 3'b000,
    DRIVE   = 3'b001,
    SHIFT   = 3'b010,
    REVERSE = 3'b011
  } state_t;

  state_t              state_reg, state_next;
  logic [GEAR_W-1:0]   gear_reg, gear_next;
  logic [GEAR_W-1:0]   target_reg, target_next;
  logic [DWELL_W-1:0]  dwell_reg, dwell_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                conflict_reg, conflict_next;
  logic                up_prev_reg, down_prev_reg;

  logic up_edge, down_edge, single_up, single_down;

  assign up_edge     = shift_up & ~up_prev_reg;
  assign down_edge   = shift_down & ~down_prev_reg;
  // Simultaneous edges cancel each other out
  assign single_up   = up_edge & ~down_edge;
  assign single_down = down_edge & ~up_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= NEUTRAL;
      gear_reg      <= '0;
      target_reg    <= '0;
      dwell_reg     <= '0;
      count_reg     <= '0;
      conflict_reg  <= 1'b0;
      up_prev_reg   <= 1'b0;
      down_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gear_reg      <= gear_next;
      target_reg    <= target_next;
      dwell_reg     <= dwell_next;
      count_reg     <= count_next;
      conflict_reg  <= conflict_next;
      up_prev_reg   <= shift_up;
      down_prev_reg <= shift_down;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gear_next     = gear_reg;
    target_next   = target_reg;
    dwell_next    = dwell_reg;
    count_next    = count_reg;
    conflict_next = up_edge & down_edge;

    case (state_reg)
      NEUTRAL: begin
        gear_next = '0;
        if (single_up && brake) begin
          state_next  = SHIFT;
          target_next = FIRST_GEAR;
          dwell_next  = DWELL_LOAD;
        end
`ifdef LANDROVER_REVERSE_EN
        else if (single_down && brake) begin
          state_next = REVERSE;
          gear_next  = '1;
        end
`endif
      end

      DRIVE: begin
        if (single_up) begin
          if (gear_reg < TOP_GEAR) begin
            state_next  = SHIFT;
            target_next = gear_reg + 1'b1;
            dwell_next  = DWELL_LOAD;
          end
        end else if (single_down) begin
          if (gear_reg > FIRST_GEAR) begin
            state_next  = SHIFT;
            target_next = gear_reg - 1'b1;
            dwell_next  = DWELL_LOAD;
          end else begin
            // Dropping out of first gear needs no dwell
            state_next = NEUTRAL;
            gear_next  = '0;
          end
        end
      end

      SHIFT: begin
        if (dwell_reg == '0) begin
          state_next = DRIVE;
          gear_next  = target_reg;
          if (count_reg != '1) begin
            count_next = count_reg + 1'b1;
          end
        end else begin
          dwell_next = dwell_reg - 1'b1;
        end
      end

      REVERSE: begin
`ifdef LANDROVER_REVERSE_EN
        if (single_up && brake) begin
          state_next = NEUTRAL;
          gear_next  = '0;
        end
`else
        state_next = NEUTRAL;
        gear_next  = '0;
`endif
      end

      default: begin
        state_next = NEUTRAL;
        gear_next  = '0;
        dwell_next = '0;
      end
    endcase
  end

  assign state       = state_reg;
  assign gear        = gear_reg;
  assign busy        = (state_reg == SHIFT);
  assign conflict    = conflict_reg;
  assign shift_count = count_reg;

endmodule

// File: tb/tb_landrover_gear_fsm.sv
// Scoreboard bench for landrover_gear_fsm: stimulus queues expected snapshots tagged with a
// cycle number; a negedge monitor pops and compares them. Honours LANDROVER_REVERSE_EN.
module tb_landrover_gear_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       shift_up, shift_down, brake;
  logic [2:0] state;
  logic [2:0] gear;
  logic       busy, conflict;
  logic [7:0] shift_count;

  landrover_gear_fsm #(
    .NUM_GEARS(5), .GEAR_W(3), .DWELL_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .shift_up(shift_up), .shift_down(shift_down), .brake(brake),
    .state(state), .gear(gear), .busy(busy), .conflict(conflict), .shift_count(shift_count)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ST_N = 3'b000, ST_D = 3'b001, ST_S = 3'b010, ST_R = 3'b011;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic [2:0]  g;
    logic        b;
    logic        cf;
    logic [7:0]  cnt;
  } exp_t;

  exp_t  sb[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int after, input string nm, input logic [2:0] st,
                           input logic [2:0] g, input logic b, input logic cf,
                           input logic [7:0] cnt);
    exp_t e;
    e.cyc = 32'(cyc + after);
    e.st = st; e.g = g; e.b = b; e.cf = cf; e.cnt = cnt;
    sb.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compare every snapshot whose cycle has arrived
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
      mon_e = sb.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (int'(mon_e.cyc) != cyc || state !== mon_e.st || gear !== mon_e.g ||
          busy !== mon_e.b || conflict !== mon_e.cf || shift_count !== mon_e.cnt) begin
        fails++;
        $display("FAIL %s cyc=%0d/%0d: got st=%b g=%0d busy=%b cf=%b cnt=%0d, want st=%b g=%0d busy=%b cf=%b cnt=%0d",
                 mon_n, cyc, mon_e.cyc, state, gear, busy, conflict, shift_count,
                 mon_e.st, mon_e.g, mon_e.b, mon_e.cf, mon_e.cnt);
      end else begin
        $display("ok   %s cyc=%0d st=%b g=%0d busy=%b cf=%b cnt=%0d",
                 mon_n, cyc, state, gear, busy, conflict, shift_count);
      end
    end
  end

  initial begin
    reset = 1'b0; shift_up = 1'b0; shift_down = 1'b0; brake = 1'b0;
    step(2);
    expect_at(0, "reset_hold", ST_N, 3'd0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    step(1);

    // Up request without brake is ignored in neutral
    shift_up = 1'b1;
    expect_at(1, "nobrake_e1", ST_N, 3'd0, 1'b0, 1'b0, 8'd0);
    expect_at(2, "nobrake_e2", ST_N, 3'd0, 1'b0, 1'b0, 8'd0);
    step(2); shift_up = 1'b0; step(1);

    // First engagement; a down pulse mid-dwell must be ignored
    brake = 1'b1; shift_up = 1'b1;
    expect_at(1, "engage_shift_k1", ST_S, 3'd0, 1'b1, 1'b0, 8'd0);
    expect_at(4, "engage_shift_k4", ST_S, 3'd0, 1'b1, 1'b0, 8'd0);
    expect_at(5, "engage_done", ST_D, 3'd1, 1'b0, 1'b0, 8'd1);
    step(1); shift_up = 1'b0; shift_down = 1'b1;
    step(1); shift_down = 1'b0;
    step(4);

    for (int g = 2; g <= 5; g++) begin
      shift_up = 1'b1;
      expect_at(4, $sformatf("up_to_%0d_dwell", g), ST_S, 3'(g - 1), 1'b1, 1'b0, 8'(g - 1));
      expect_at(5, $sformatf("up_to_%0d_done", g), ST_D, 3'(g), 1'b0, 1'b0, 8'(g));
      step(1); shift_up = 1'b0; step(5);
    end

    // Saturation at top gear, held level
    shift_up = 1'b1;
    expect_at(1, "top_sat", ST_D, 3'd5, 1'b0, 1'b0, 8'd5);
    expect_at(10, "top_held", ST_D, 3'd5, 1'b0, 1'b0, 8'd5);
    step(11); shift_up = 1'b0; step(1);

    // Downshift with held level: exactly one shift
    shift_down = 1'b1;
    expect_at(4, "down5_dwell", ST_S, 3'd5, 1'b1, 1'b0, 8'd5);
    expect_at(5, "down_to_4", ST_D, 3'd4, 1'b0, 1'b0, 8'd6);
    expect_at(8, "down_held", ST_D, 3'd4, 1'b0, 1'b0, 8'd6);
    step(8); shift_down = 1'b0; step(1);
    shift_down = 1'b1;
    expect_at(5, "down_to_3", ST_D, 3'd3, 1'b0, 1'b0, 8'd7);
    step(1); shift_down = 1'b0; step(5);

    // Simultaneous edges: conflict pulse, no action
    shift_up = 1'b1; shift_down = 1'b1;
    expect_at(1, "conflict_pulse", ST_D, 3'd3, 1'b0, 1'b1, 8'd7);
    expect_at(2, "conflict_clear", ST_D, 3'd3, 1'b0, 1'b0, 8'd7);
    step(3); shift_up = 1'b0; shift_down = 1'b0; step(1);

    shift_down = 1'b1;
    expect_at(5, "down_to_2", ST_D, 3'd2, 1'b0, 1'b0, 8'd8);
    step(1); shift_down = 1'b0; step(5);
    shift_down = 1'b1;
    expect_at(5, "down_to_1", ST_D, 3'd1, 1'b0, 1'b0, 8'd9);
    step(1); shift_down = 1'b0; step(5);
    shift_down = 1'b1;
    expect_at(1, "first_to_neutral", ST_N, 3'd0, 1'b0, 1'b0, 8'd9);
    step(1); shift_down = 1'b0; step(2);

    // Reset in the middle of a 2->3 shift
    for (int g = 1; g <= 2; g++) begin
      shift_up = 1'b1;
      expect_at(5, $sformatf("reup_to_%0d", g), ST_D, 3'(g), 1'b0, 1'b0, 8'(9 + g));
      step(1); shift_up = 1'b0; step(5);
    end
    shift_up = 1'b1;
    expect_at(1, "shift_2_3_start", ST_S, 3'd2, 1'b1, 1'b0, 8'd11);
    step(2);
    shift_up = 1'b0; reset = 1'b0;
    expect_at(0, "reset_mid_shift", ST_N, 3'd0, 1'b0, 1'b0, 8'd0);
    step(2);

    // Request already high when reset releases counts as an edge
    shift_up = 1'b1;
    step(1);
    reset = 1'b1;
    expect_at(1, "post_reset_edge", ST_S, 3'd0, 1'b1, 1'b0, 8'd0);
    expect_at(5, "post_reset_done", ST_D, 3'd1, 1'b0, 1'b0, 8'd1);
    step(1); shift_up = 1'b0; step(5);

    shift_down = 1'b1;
    expect_at(1, "back_to_neutral", ST_N, 3'd0, 1'b0, 1'b0, 8'd1);
    step(1); shift_down = 1'b0; step(1);

    shift_down = 1'b1;
`ifdef LANDROVER_REVERSE_EN
    expect_at(1, "reverse_enter", ST_R, 3'b111, 1'b0, 1'b0, 8'd1);
`else
    expect_at(1, "reverse_ignored", ST_N, 3'b000, 1'b0, 1'b0, 8'd1);
`endif
    step(1); shift_down = 1'b0; step(1);
`ifdef LANDROVER_REVERSE_EN
    shift_up = 1'b1;
    expect_at(1, "reverse_exit", ST_N, 3'd0, 1'b0, 1'b0, 8'd1);
    step(1); shift_up = 1'b0; step(1);
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
